led_seq_ctrl: RTL and testbench
===============================

// Module: led_seq_ctrl
// PURPOSE
//  Autonomous LED pattern sequencer sharing the Avalon-MM bus with the CPU. The CPU loads a
//  small pattern table and step period through an Avalon-MM slave; an Avalon-MM master port
//  then writes one table entry per step to the 4-bit LED PIO data register (offset 0).
//  The PIO stays CPU-writable; this block only sequences it. Optional done interrupt.
// PARAMETERS
//  NUM_LEDS  4   width of each pattern entry / PIO data field
//  DEPTH     8   pattern table entries (power of 2); IDX_W = log2(DEPTH)
//  PER_W     24  width of step period register (clock cycles)
// PORTS
//  clk            in   1        system clock, single domain
//  reset_n        in   1        asynchronous, active-low reset
//  s_address      in   3        slave register select
//  s_chipselect   in   1        slave select
//  s_write_n      in   1        slave write strobe, active low
//  s_writedata    in   32       slave write data
//  s_readdata     out  32       slave read data, zero-extended, 0 wait states (combinational)
//  m_address      out  3        master address into PIO (always 0)
//  m_chipselect   out  1        master transfer request
//  m_write_n      out  1        master write strobe, active low
//  m_writedata    out  32       {zeros, pattern[NUM_LEDS-1:0]}
//  m_waitrequest  in   1        fabric stall; transfer held while 1
//  irq            out  1        done & CTRL.IRQ_EN
// BEHAVIOUR
//  Register map (s_address): 0 CTRL: [0]RUN [1]LOOP [2]IRQ_EN [6:4]LAST index
//   1 PERIOD[PER_W-1:0]; 0 treated as 1. 2 TBL_ADDR[IDX_W-1:0]. 3 TBL_DATA: write stores
//   table[TBL_ADDR], then TBL_ADDR+1 (wraps DEPTH-1->0); read returns table[TBL_ADDR].
//   4 STATUS (RO except W1C): [0]BUSY [1]DONE (sticky, write 1 clears) [6:4]current idx.
//   Unmapped addresses read 0, writes ignored.
//  Reset: all registers, table, idx, counter = 0; FSM IDLE; m_chipselect=0, m_write_n=1,
//   m_address=0, m_writedata=0, irq=0.
//  FSM: IDLE -> ISSUE when RUN=1 (idx<=0); cycle after CTRL write with RUN=1 asserts
//   m_chipselect. ISSUE drives chipselect=1, write_n=0, writedata=table[idx] registered on
//   entry and held stable while m_waitrequest=1. Transfer accepted on edge with
//   waitrequest=0 -> WAIT, counter<=PERIOD-1. WAIT: decrement; at counter==0 -> ADVANCE.
//   ADVANCE (combinational in WAIT exit): idx<LAST -> idx+1, ISSUE; idx==LAST & LOOP ->
//   idx 0, ISSUE; idx==LAST & !LOOP -> DONE<=1, RUN<=0, IDLE.
//  Timing: with waitrequest=0, accepted writes spaced exactly PERIOD+1 cycles.
//  LAST > DEPTH-1 is clamped to DEPTH-1.
//  RUN cleared by CPU: in ISSUE the in-flight transfer completes (never abandoned
//   mid-handshake), then IDLE; in WAIT -> IDLE next cycle. No further writes. DONE not set.
//  RUN rewritten 1 while running: no restart. Restart requires IDLE first.
//  Table/PERIOD writes during run allowed: table change seen at next ISSUE entry; PERIOD
//   change at next counter load. Same-cycle DONE set and W1C clear: set wins.
//  BUSY = (state != IDLE). Async reset mid-transfer drops chipselect immediately.
// STRUCTURE
//  Package led_seq_pkg: state enum {IDLE,ISSUE,WAIT}, register address localparams,
//   CTRL/STATUS bit positions, PIO_DATA_OFS=0.
//  Sub-module led_seq_step_timer: loadable PER_W down-counter, load/en in, zero flag out.
//  Table as DEPTH x NUM_LEDS register array (small; no RAM inference).
// TESTING
//  1 Table {1,2,4,8}, PERIOD=3, LAST=3, LOOP=0, RUN -> PIO writes 1,2,4,8 spaced 4 cycles;
//    DONE=1, RUN=0, BUSY=0 after last.
//  2 Same with LOOP=1 -> sequence 1,2,4,8,1,2... ; clear RUN in WAIT -> no further writes.
//  3 m_waitrequest high 5 cycles on 2nd write -> address/data/strobes stable; next write
//    4 cycles after acceptance; clear RUN during stall -> transfer completes, then IDLE.
//  4 PERIOD=0 -> treated as 1 (writes 2 cycles apart); TBL_DATA auto-increment wraps 7->0.
//  5 IRQ_EN=1 -> irq rises with DONE; W1C to STATUS[1] drops irq; simultaneous set wins.
//  6 reset_n low mid-ISSUE -> outputs at reset values asynchronously; table reads 0.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and register map for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PERIOD   = 3'd1;
    localparam logic [2:0] ADDR_TBL_ADDR = 3'd2;
    localparam logic [2:0] ADDR_TBL_DATA = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;

    localparam int unsigned CTRL_RUN      = 0;
    localparam int unsigned CTRL_LOOP     = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned CTRL_LAST_LSB = 4;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_IDX_LSB = 4;

    // Width of the index fields in CTRL and STATUS
    localparam int unsigned FIELD_W = 3;

    localparam logic [2:0] PIO_DATA_OFS = 3'd0;

    function automatic logic [FIELD_W-1:0] clamp_idx(
        input logic [FIELD_W-1:0] v,
        input logic [FIELD_W-1:0] max
    );
        return (v > max) ? max : v;
    endfunction

endpackage

// File: rtl/led_seq_step_timer.sv
// Loadable down-counter that paces the sequencer between PIO writes.
module led_seq_step_timer #(
    parameter int unsigned PER_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [PER_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    localparam logic [PER_W-1:0] PER_ONE = 1;

    logic [PER_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - PER_ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: CPU-loaded table played out to the LED PIO over an Avalon-MM master.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PER_W    = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        irq
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [PER_W-1:0] PER_ONE = 1;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_run;
    logic                  r_loop;
    logic                  r_irq_en;
    logic [IDX_W-1:0]      r_last;
    logic [PER_W-1:0]      r_period;
    logic [IDX_W-1:0]      r_taddr;
    logic [NUM_LEDS-1:0]   r_tbl [DEPTH];
    logic                  r_done;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_LEDS-1:0]   r_pat;

    logic                  w_wr;
    logic                  w_ctrl_wr;
    logic                  w_period_wr;
    logic                  w_taddr_wr;
    logic                  w_tdata_wr;
    logic                  w_status_wr;
    logic                  w_cpu_run;
    logic                  w_run_d;
    logic                  w_zero;
    logic                  w_start;
    logic                  w_expire;
    logic                  w_at_last;
    logic                  w_done_set;
    logic                  w_advance;
    logic                  w_accept;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [FIELD_W-1:0]    w_last_in;
    logic [PER_W-1:0]      w_period_m1;

    assign w_wr        = s_chipselect & ~s_write_n;
    assign w_ctrl_wr   = w_wr & (s_address == ADDR_CTRL);
    assign w_period_wr = w_wr & (s_address == ADDR_PERIOD);
    assign w_taddr_wr  = w_wr & (s_address == ADDR_TBL_ADDR);
    assign w_tdata_wr  = w_wr & (s_address == ADDR_TBL_DATA);
    assign w_status_wr = w_wr & (s_address == ADDR_STATUS);

    // RUN as the CPU leaves it this cycle; a clear lands before any further step is taken
    assign w_cpu_run  = w_ctrl_wr ? s_writedata[CTRL_RUN] : r_run;
    assign w_start    = (r_state == IDLE) & w_cpu_run;
    assign w_accept   = (r_state == ISSUE) & ~m_waitrequest;
    assign w_expire   = (r_state == WAIT) & w_zero & w_cpu_run;
    assign w_at_last  = (r_idx >= r_last);
    assign w_done_set = w_expire & w_at_last & ~r_loop;
    assign w_advance  = w_expire & ~w_done_set;
    assign w_run_d    = w_done_set ? 1'b0 : w_cpu_run;
    assign w_idx_nxt  = w_at_last ? '0 : r_idx + IDX_ONE;
    assign w_last_in  = clamp_idx(s_writedata[CTRL_LAST_LSB +: FIELD_W], FIELD_W'(DEPTH - 1));
    assign w_period_m1 = (r_period == '0) ? '0 : r_period - PER_ONE;

    led_seq_step_timer #(
        .PER_W (PER_W)
    ) u_timer (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_load     (w_accept),
        .i_load_val (w_period_m1),
        .i_en       (r_state == WAIT),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cpu_run) w_state_nxt = ISSUE;
            ISSUE:   if (!m_waitrequest) w_state_nxt = w_cpu_run ? WAIT : IDLE;
            WAIT: begin
                if (!w_cpu_run || w_done_set) begin
                    w_state_nxt = IDLE;
                end else if (w_zero) begin
                    w_state_nxt = ISSUE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_chipselect = (r_state == ISSUE);
        m_write_n    = (r_state != ISSUE);
        m_address    = PIO_DATA_OFS;
        m_writedata  = '0;
        if (r_state == ISSUE) begin
            m_writedata[NUM_LEDS-1:0] = r_pat;
        end
        irq = r_done & r_irq_en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run    <= 1'b0;
            r_loop   <= 1'b0;
            r_irq_en <= 1'b0;
            r_last   <= '0;
            r_period <= '0;
            r_taddr  <= '0;
            r_tbl    <= '{default: '0};
            r_done   <= 1'b0;
            r_idx    <= '0;
            r_pat    <= '0;
        end else begin
            r_run <= w_run_d;
            if (w_ctrl_wr) begin
                r_loop   <= s_writedata[CTRL_LOOP];
                r_irq_en <= s_writedata[CTRL_IRQ_EN];
                r_last   <= w_last_in[IDX_W-1:0];
            end
            if (w_period_wr) begin
                r_period <= s_writedata[PER_W-1:0];
            end
            if (w_taddr_wr) begin
                r_taddr <= s_writedata[IDX_W-1:0];
            end else if (w_tdata_wr) begin
                r_tbl[r_taddr] <= s_writedata[NUM_LEDS-1:0];
                r_taddr        <= r_taddr + IDX_ONE;
            end
            // A DONE set in the same cycle as a W1C clear takes precedence
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_status_wr && s_writedata[STAT_DONE]) begin
                r_done <= 1'b0;
            end
            if (w_start) begin
                r_idx <= '0;
                r_pat <= r_tbl[0];
            end else if (w_advance) begin
                r_idx <= w_idx_nxt;
                r_pat <= r_tbl[w_idx_nxt];
            end
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            ADDR_CTRL: begin
                s_readdata[CTRL_RUN]                = r_run;
                s_readdata[CTRL_LOOP]               = r_loop;
                s_readdata[CTRL_IRQ_EN]             = r_irq_en;
                s_readdata[CTRL_LAST_LSB +: IDX_W]  = r_last;
            end
            ADDR_PERIOD:   s_readdata[PER_W-1:0]    = r_period;
            ADDR_TBL_ADDR: s_readdata[IDX_W-1:0]    = r_taddr;
            ADDR_TBL_DATA: s_readdata[NUM_LEDS-1:0] = r_tbl[r_taddr];
            ADDR_STATUS: begin
                s_readdata[STAT_BUSY]              = (r_state != IDLE);
                s_readdata[STAT_DONE]              = r_done;
                s_readdata[STAT_IDX_LSB +: IDX_W]  = r_idx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: expected PIO writes queued at stimulus, checked on acceptance.
module tb_led_seq_ctrl;

    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_PER  = 3'd1;
    localparam logic [2:0] A_TADR = 3'd2;
    localparam logic [2:0] A_TDAT = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic        irq;

    typedef struct {
        logic [31:0] data;
        int unsigned gap;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned n_acc = 0;
    int unsigned stall_cnt = 0;
    int unsigned base;
    int unsigned sbase;

    led_seq_ctrl #(
        .NUM_LEDS (4),
        .DEPTH    (8),
        .PER_W    (24)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        s_address    = a;
        s_chipselect = 1'b1;
        s_write_n    = 1'b1;
        #1;
        d = s_readdata;
        s_chipselect = 1'b0;
        chk_eq(tag, d, exp);
    endtask

    task automatic push(input logic [31:0] d, input int unsigned gap);
        exp_t e;
        e.data = d;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int unsigned max);
        int unsigned n = 0;
        while (sb.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) chk_eq("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_acc(input int unsigned target, input int unsigned max);
        int unsigned n = 0;
        while (n_acc < target && n < max) begin
            @(posedge clk);
            n++;
        end
        if (n_acc < target) chk_eq("acc_timeout", n_acc, target);
    endtask

    task automatic wait_stall(input int unsigned target, input int unsigned max);
        int unsigned n = 0;
        while (stall_cnt < target && n < max) begin
            @(posedge clk);
            n++;
        end
        if (stall_cnt < target) chk_eq("stall_timeout", stall_cnt, target);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: stall stability and accepted-write scoreboard
    initial begin
        logic        stall_seen;
        logic [31:0] stall_data;
        logic [31:0] stall_ctl;
        int unsigned last_acc;
        exp_t        e;
        stall_seen = 1'b0;
        stall_data = '0;
        stall_ctl  = '0;
        last_acc   = 0;
        forever begin
            @(negedge clk);
            if (reset_n && m_chipselect && !m_write_n && m_waitrequest) begin
                stall_cnt++;
                if (stall_seen) begin
                    chk_eq("stall_data", m_writedata, stall_data);
                    chk_eq("stall_ctl", {27'd0, m_address, m_chipselect, m_write_n}, stall_ctl);
                end
                stall_seen = 1'b1;
                stall_data = m_writedata;
                stall_ctl  = {27'd0, m_address, m_chipselect, m_write_n};
            end else begin
                stall_seen = 1'b0;
            end
            if (reset_n && m_chipselect && !m_write_n && !m_waitrequest) begin
                n_acc++;
                if (sb.size() == 0) begin
                    chk_eq("unexpected_wr", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk_eq("wr_data", m_writedata, e.data);
                    chk_eq("wr_addr", {29'd0, m_address}, 32'd0);
                    if (e.gap != 0) chk_eq("wr_gap", cyc - last_acc, e.gap);
                end
                last_acc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        s_address     = '0;
        s_chipselect  = 1'b0;
        s_write_n     = 1'b1;
        s_writedata   = '0;
        m_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        chk_eq("rst_cs", m_chipselect, 0);
        chk_eq("rst_wn", m_write_n, 1);
        chk_eq("rst_wd", m_writedata, 0);
        chk_eq("rst_irq", irq, 0);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_status", A_STAT, 32'h0);

        // One-shot sequence
        cpu_wr(A_TADR, 0);
        cpu_wr(A_TDAT, 1);
        cpu_wr(A_TDAT, 2);
        cpu_wr(A_TDAT, 4);
        cpu_wr(A_TDAT, 8);
        rd_chk("tbl_addr_inc", A_TADR, 32'd4);
        cpu_wr(A_PER, 3);
        push(1, 0); push(2, 4); push(4, 4); push(8, 4);
        base = n_acc;
        cpu_wr(A_CTRL, 32'h31);
        wait_drain(100);
        repeat (8) @(posedge clk);
        rd_chk("t1_status", A_STAT, 32'h32);
        rd_chk("t1_ctrl", A_CTRL, 32'h30);
        chk_eq("t1_count", n_acc - base, 4);

        // Looping, stopped by the CPU in WAIT
        cpu_wr(A_STAT, 32'h2);
        push(1, 0); push(2, 4); push(4, 4); push(8, 4); push(1, 4); push(2, 4);
        base = n_acc;
        cpu_wr(A_CTRL, 32'h33);
        wait_drain(150);
        cpu_wr(A_CTRL, 32'h32);
        repeat (20) @(posedge clk);
        chk_eq("t2_count", n_acc - base, 6);
        rd_chk("t2_status", A_STAT, 32'h10);

        // Fabric stall on the second write
        cpu_wr(A_STAT, 32'h2);
        push(1, 0); push(2, 9); push(4, 4); push(8, 4);
        base = n_acc;
        cpu_wr(A_CTRL, 32'h31);
        wait_acc(base + 1, 20);
        @(posedge clk);
        #1 m_waitrequest = 1'b1;
        sbase = stall_cnt;
        wait_stall(sbase + 5, 40);
        #1 m_waitrequest = 1'b0;
        wait_drain(100);
        repeat (8) @(posedge clk);
        rd_chk("t3_status", A_STAT, 32'h32);

        // RUN cleared during a stall: transfer completes, then idle
        cpu_wr(A_STAT, 32'h2);
        push(1, 0);
        base = n_acc;
        @(posedge clk);
        #1 m_waitrequest = 1'b1;
        cpu_wr(A_CTRL, 32'h31);
        sbase = stall_cnt;
        wait_stall(sbase + 2, 20);
        cpu_wr(A_CTRL, 32'h30);
        repeat (2) @(posedge clk);
        #1 m_waitrequest = 1'b0;
        wait_drain(20);
        repeat (12) @(posedge clk);
        chk_eq("t3b_count", n_acc - base, 1);
        rd_chk("t3b_status", A_STAT, 32'h00);

        // PERIOD=0 and table address wrap
        cpu_wr(A_PER, 0);
        cpu_wr(A_TADR, 6);
        cpu_wr(A_TDAT, 5);
        cpu_wr(A_TDAT, 6);
        cpu_wr(A_TDAT, 3);
        rd_chk("tbl_wrap_addr", A_TADR, 32'd1);
        cpu_wr(A_TADR, 7);
        rd_chk("tbl7", A_TDAT, 32'd6);
        cpu_wr(A_TADR, 0);
        rd_chk("tbl0_wrap", A_TDAT, 32'd3);
        push(3, 0); push(2, 2);
        cpu_wr(A_CTRL, 32'h11);
        wait_drain(40);
        repeat (6) @(posedge clk);
        rd_chk("t4_status", A_STAT, 32'h12);

        // Interrupt and DONE W1C
        cpu_wr(A_STAT, 32'h2);
        push(3, 0);
        cpu_wr(A_CTRL, 32'h05);
        wait_drain(20);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_eq("irq_set", irq, 1);
        rd_chk("t5_status", A_STAT, 32'h02);
        cpu_wr(A_STAT, 32'h2);
        chk_eq("irq_clr", irq, 0);
        rd_chk("t5_status_clr", A_STAT, 32'h00);
        push(3, 0);
        cpu_wr(A_CTRL, 32'h05);
        @(negedge clk);
        cpu_wr(A_STAT, 32'h2);
        wait_drain(10);
        chk_eq("irq_set_wins", irq, 1);
        rd_chk("t5_set_wins", A_STAT, 32'h02);

        // Asynchronous reset in the middle of ISSUE
        @(posedge clk);
        #1 m_waitrequest = 1'b1;
        cpu_wr(A_PER, 3);
        cpu_wr(A_CTRL, 32'h35);
        sbase = stall_cnt;
        wait_stall(sbase + 1, 20);
        @(negedge clk);
        chk_eq("pre_rst_cs", m_chipselect, 1);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("arst_cs", m_chipselect, 0);
        chk_eq("arst_wn", m_write_n, 1);
        chk_eq("arst_wd", m_writedata, 0);
        chk_eq("arst_addr", {29'd0, m_address}, 0);
        chk_eq("arst_irq", irq, 0);
        m_waitrequest = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd_chk("t6_ctrl", A_CTRL, 32'h0);
        rd_chk("t6_status", A_STAT, 32'h0);
        rd_chk("t6_period", A_PER, 32'h0);
        rd_chk("t6_taddr", A_TADR, 32'h0);
        rd_chk("t6_tbl0", A_TDAT, 32'h0);
        cpu_wr(A_TADR, 7);
        rd_chk("t6_tbl7", A_TDAT, 32'h0);
        repeat (10) @(posedge clk);
        chk_eq("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
